montgomery_squarer_arbiter: RTL

- Round-robin scheduler that shares one Montgomery squarer stream datapath among NUM_REQ requesters (e.g. parallel encryption lanes).
- Grants one requester at a time and muxes its input block stream into the squarer.
- Routes the squarer's result stream back to the granted requester, and sequences the N/k constant block indices on the squarer's consume handshakes.
- Holds the grant until the whole job (input load plus all result beats) completes.

---
 rtl/montgomery_squarer_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/montgomery_squarer_arbiter.sv
// -----------------------------------------------------------------------------
// montgomery_squarer_arbiter
//
// Purpose:
//   Shares one Montgomery squarer stream datapath among NUM_REQ requesters.
//   A round-robin scheduler grants one requester at a time. It streams that
//   requester's input blocks into the squarer and routes the squarer's result
//   beats back to it. It also sequences the N/k constant block indices for the
//   external constant ROMs. The grant is held until the whole job completes:
//   the input load plus every result beat.
//
// Ports:
//   clk_in           - clock
//   rst_in           - synchronous active-high reset
//   req_in           - per-requester job request (level)
//   req_block_in     - per-requester input block, requester i at
//                      [i*REGISTER_SIZE +: REGISTER_SIZE]
//   req_valid_in     - per-requester input block valid
//   grant_out        - one-hot grant, zero when idle
//   result_block_out - result block, broadcast to all requesters
//   result_valid_out - one-hot result valid, granted requester only
//   result_last_out  - marks the final result beat of a job
//   done_out         - one-cycle completion pulse to the granted requester
//   sq_block_out     - block to the squarer data input
//   sq_valid_out     - squarer data valid
//   sq_rst_out       - squarer reset
//   sq_block_in      - squarer result block
//   sq_valid_in      - squarer result valid
//   consumed_N_in    - squarer consumed one N constant block
//   consumed_k_in    - squarer consumed one k constant block
//   N_idx_out        - N constant block index
//   k_idx_out        - k constant block index
// -----------------------------------------------------------------------------
module montgomery_squarer_arbiter #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048,
  parameter int NUM_REQ       = 4,
  parameter int RESULT_BEATS  = (BITS_IN_NUM - 1) * (2 * BITS_IN_NUM / REGISTER_SIZE)
) (
  input  logic                                            clk_in,
  input  logic                                            rst_in,
  input  logic [NUM_REQ-1:0]                              req_in,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0]                req_block_in,
  input  logic [NUM_REQ-1:0]                              req_valid_in,
  output logic [NUM_REQ-1:0]                              grant_out,
  output logic [REGISTER_SIZE-1:0]                        result_block_out,
  output logic [NUM_REQ-1:0]                              result_valid_out,
  output logic                                            result_last_out,
  output logic [NUM_REQ-1:0]                              done_out,
  output logic [REGISTER_SIZE-1:0]                        sq_block_out,
  output logic                                            sq_valid_out,
  output logic                                            sq_rst_out,
  input  logic [REGISTER_SIZE-1:0]                        sq_block_in,
  input  logic                                            sq_valid_in,
  input  logic                                            consumed_N_in,
  input  logic                                            consumed_k_in,
  output logic [$clog2(2*BITS_IN_NUM/REGISTER_SIZE)-1:0]  N_idx_out,
  output logic [$clog2(2*BITS_IN_NUM/REGISTER_SIZE)-1:0]  k_idx_out
);

  localparam int JOB_BLOCKS = 2 * BITS_IN_NUM / REGISTER_SIZE;
  localparam int IDX_W      = $clog2(JOB_BLOCKS);
  localparam int GNT_W      = $clog2(NUM_REQ);
  localparam int LCNT_W     = $clog2(JOB_BLOCKS + 1);
  localparam int RCNT_W     = $clog2(RESULT_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [GNT_W-1:0]          r_grantee;
  logic [GNT_W-1:0]          r_ptr;
  logic [NUM_REQ-1:0]        r_grant;
  logic [NUM_REQ-1:0]        r_done;
  logic                      r_sqRst;
  logic [LCNT_W-1:0]         r_loadCnt;
  logic [RCNT_W-1:0]         r_resCnt;
  logic [IDX_W-1:0]          r_nIdx;
  logic [IDX_W-1:0]          r_kIdx;

  logic [REGISTER_SIZE-1:0]  w_blocks [NUM_REQ];
  logic [GNT_W-1:0]          w_pick;
  logic                      w_sqValid;
  logic                      w_resBeat;
  logic                      w_lastBeat;

  // First requesting index at or above the pointer, wrapping around. The loop
  // runs from the farthest offset down to the nearest so that the nearest
  // requester is the last one written.
  function automatic logic [GNT_W-1:0] pickNext(input logic [NUM_REQ-1:0] req,
                                                input logic [GNT_W-1:0]   ptr);
    logic [GNT_W-1:0] pick;
    int               idx;
    pick = ptr;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[GNT_W'(idx)]) pick = GNT_W'(idx);
    end
    return pick;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_blocks[gi] = req_block_in[gi*REGISTER_SIZE +: REGISTER_SIZE];
    end
  endgenerate

  assign w_pick = pickNext(req_in, r_ptr);

  // Load path and result path are pure pass-throughs. This keeps the squarer's
  // stream timing identical to a direct connection to the granted requester.
  always_comb begin
    sq_block_out     = '0;
    w_sqValid        = 1'b0;
    w_resBeat        = 1'b0;
    result_block_out = '0;
    if (r_state == LOAD) begin
      sq_block_out = w_blocks[r_grantee];
      w_sqValid    = req_valid_in[r_grantee];
    end
    if (r_state == RUN) begin
      w_resBeat        = sq_valid_in;
      result_block_out = sq_block_in;
    end
  end

  assign w_lastBeat       = w_resBeat && (r_resCnt == RCNT_W'(RESULT_BEATS - 1));
  assign sq_valid_out     = w_sqValid;
  assign result_valid_out = w_resBeat ? r_grant : '0;
  assign result_last_out  = w_lastBeat;
  assign grant_out        = r_grant;
  assign done_out         = r_done;
  assign sq_rst_out       = r_sqRst;
  assign N_idx_out        = r_nIdx;
  assign k_idx_out        = r_kIdx;

  // Job sequencer. done and the squarer reset are registered with the entry
  // into DONE, so both are high exactly while the FSM sits in DONE.
  // A reset in mid-job simply drops all job state; no done pulse is produced.
  // The constant indices run independently of the job phase. The clear in
  // DONE takes priority, so a consume strobe arriving in that cycle is lost.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_grantee <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_sqRst   <= 1'b1;
      r_loadCnt <= '0;
      r_resCnt  <= '0;
      r_nIdx    <= '0;
      r_kIdx    <= '0;
    end else begin
      r_done  <= '0;
      r_sqRst <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req_in) begin
            r_grantee <= w_pick;
            r_grant   <= NUM_REQ'(1) << w_pick;
            r_state   <= GRANT;
          end
        end
        GRANT: begin
          r_loadCnt <= '0;
          r_state   <= LOAD;
        end
        LOAD: begin
          if (w_sqValid) begin
            r_loadCnt <= r_loadCnt + 1'b1;
            if (r_loadCnt == LCNT_W'(JOB_BLOCKS - 1)) begin
              r_resCnt <= '0;
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          if (w_resBeat) begin
            r_resCnt <= r_resCnt + 1'b1;
            if (w_lastBeat) begin
              r_done  <= r_grant;
              r_sqRst <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_ptr     <= (r_grantee == GNT_W'(NUM_REQ - 1)) ? '0 : r_grantee + 1'b1;
          r_grant   <= '0;
          r_loadCnt <= '0;
          r_resCnt  <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (r_state == DONE) begin
        r_nIdx <= '0;
        r_kIdx <= '0;
      end else begin
        if (consumed_N_in)
          r_nIdx <= (r_nIdx == IDX_W'(JOB_BLOCKS - 1)) ? '0 : r_nIdx + 1'b1;
        if (consumed_k_in)
          r_kIdx <= (r_kIdx == IDX_W'(JOB_BLOCKS - 1)) ? '0 : r_kIdx + 1'b1;
      end
    end
  end

endmodule
